// File: rtl/iofocus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iofocus_pkg
// Description : Shared definitions for the IO-focus ring manager: command
//               codes, controller state encoding and the "no task" id.
// Revision    : 1.0 - initial release
// ============================================================================
package iofocus_pkg;

    // Command codes on the 7-bit OS command bus. Every other code is a NOP.
    localparam logic [6:0] IOF_INSERT  = 7'd16;
    localparam logic [6:0] IOF_REMOVE  = 7'd17;
    localparam logic [6:0] IOF_GETNXT  = 7'd18;
    localparam logic [6:0] IOF_GETPRV  = 7'd19;
    localparam logic [6:0] IOF_GETHEAD = 7'd20;
    localparam logic [6:0] IOF_FLUSH   = 7'd21;

    // "No task" result for the default 6-bit task-id width (tid_o is TID_W+1 wide).
    localparam int              IOF_TID_W_DEF = 6;
    localparam logic [IOF_TID_W_DEF:0] TID_NONE = '1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_REJECT = 4'd1,
        ST_RDLINK = 4'd2,
        ST_INS0   = 4'd3,
        ST_INS1   = 4'd4,
        ST_INS2   = 4'd5,
        ST_INS3   = 4'd6,
        ST_REM1   = 4'd7,
        ST_REM2   = 4'd8,
        ST_REM3   = 4'd9,
        ST_FLUSH  = 4'd10
    } iof_state_e;

    // True for the codes the controller acts on.
    function automatic logic iof_is_cmd(input logic [6:0] cmd);
        return (cmd >= IOF_INSERT) && (cmd <= IOF_FLUSH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iofocus_linkram.sv
`default_nettype none
// ============================================================================
// Module      : iofocus_linkram
// Description : Next/previous link storage for all focus rings. Two arrays
//               (nxt, prv) addressed by {list, tid}; combinational read,
//               one synchronous write per array per cycle. Not reset: a link
//               is only ever followed for a task whose membership bit is set.
// Ports       : clk_i                       clock
//               nxt_raddr_i / nxt_rdata_o   nxt array read port
//               nxt_we_i/_waddr_i/_wdata_i  nxt array write port
//               prv_raddr_i / prv_rdata_o   prv array read port
//               prv_we_i/_waddr_i/_wdata_i  prv array write port
// Revision    : 1.0 - initial release
// ============================================================================
module iofocus_linkram #(
    parameter int TID_W  = 6,
    parameter int LIST_W = 2
) (
    input  logic                      clk_i,
    input  logic [LIST_W+TID_W-1:0]   nxt_raddr_i,
    output logic [TID_W-1:0]          nxt_rdata_o,
    input  logic                      nxt_we_i,
    input  logic [LIST_W+TID_W-1:0]   nxt_waddr_i,
    input  logic [TID_W-1:0]          nxt_wdata_i,
    input  logic [LIST_W+TID_W-1:0]   prv_raddr_i,
    output logic [TID_W-1:0]          prv_rdata_o,
    input  logic                      prv_we_i,
    input  logic [LIST_W+TID_W-1:0]   prv_waddr_i,
    input  logic [TID_W-1:0]          prv_wdata_i
);

    localparam int c_depth = 2 ** (LIST_W + TID_W);

    logic [TID_W-1:0] nxt_mem [c_depth];
    logic [TID_W-1:0] prv_mem [c_depth];

    always_ff @(posedge clk_i) begin
        if (nxt_we_i) begin
            nxt_mem[nxt_waddr_i] <= nxt_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (prv_we_i) begin
            prv_mem[prv_waddr_i] <= prv_wdata_i;
        end
    end

    assign nxt_rdata_o = nxt_mem[nxt_raddr_i];
    assign prv_rdata_o = prv_mem[prv_raddr_i];

endmodule
`default_nettype wire

// File: rtl/iofocus_ring.sv
`default_nettype none
// ============================================================================
// Module      : iofocus_ring
// Description : Multi-ring IO-focus manager. NLIST independent circular
//               doubly-linked rings of task ids; the head of each ring owns
//               that channel's IO focus. Insert (at tail), remove (with head
//               repair), rotate forward/back, peek, flush, counts, error flag.
// Ports       : clk_i   in  clock
//               rst_ni  in  asynchronous active-low reset
//               cmd_i   in  command code, sampled while done_o=1
//               list_i  in  target ring
//               tid_i   in  task operand, held until done_o returns high
//               tid_o   out result task id, all-ones = none
//               err_o   out last command rejected
//               cnt_o   out member count of the ring last addressed
//               done_o  out 1 = idle / result valid
// Revision    : 1.0 - initial release
// ============================================================================
module iofocus_ring
    import iofocus_pkg::*;
#(
    parameter int TID_W  = 6,
    parameter int NLIST  = 4,
    parameter int LIST_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [6:0]        cmd_i,
    input  logic [LIST_W-1:0] list_i,
    input  logic [TID_W-1:0]  tid_i,
    output logic [TID_W:0]    tid_o,
    output logic              err_o,
    output logic [TID_W:0]    cnt_o,
    output logic              done_o
);

    localparam int                 c_ntask    = 2 ** TID_W;
    localparam int                 c_addr_w   = LIST_W + TID_W;
    localparam logic [TID_W:0]     c_tid_none = {(TID_W + 1){1'b1}};
    localparam logic [TID_W:0]     c_cnt_one  = (TID_W + 1)'(1);
    localparam logic [LIST_W:0]    c_nlist    = (LIST_W + 1)'(NLIST);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    iof_state_e                     state_q,   state_d;
    logic [6:0]                     cmd_q,     cmd_d;
    logic [LIST_W-1:0]              list_q,    list_d;
    logic [TID_W-1:0]               tid_q,     tid_d;
    logic [TID_W-1:0]               pv_q,      pv_d;
    logic [TID_W-1:0]               nx_q,      nx_d;
    logic [NLIST-1:0][TID_W-1:0]    head_q,    head_d;
    logic [NLIST-1:0]               headv_q,   headv_d;
    logic [NLIST-1:0][TID_W:0]      cnt_q,     cnt_d;
    logic [NLIST-1:0][c_ntask-1:0]  member_q,  member_d;
    logic [TID_W:0]                 res_tid_q, res_tid_d;
    logic                           res_err_q, res_err_d;
    logic [TID_W:0]                 res_cnt_q, res_cnt_d;

    // ------------------------------------------------------------------
    // Link RAM interface
    // ------------------------------------------------------------------
    logic [c_addr_w-1:0]  w_nxt_raddr, w_prv_raddr;
    logic [TID_W-1:0]     w_nxt_rdata, w_prv_rdata;
    logic                 w_nxt_we,    w_prv_we;
    logic [c_addr_w-1:0]  w_nxt_waddr, w_prv_waddr;
    logic [TID_W-1:0]     w_nxt_wdata, w_prv_wdata;

    iofocus_linkram #(
        .TID_W  (TID_W),
        .LIST_W (LIST_W)
    ) u_linkram (
        .clk_i       (clk_i),
        .nxt_raddr_i (w_nxt_raddr),
        .nxt_rdata_o (w_nxt_rdata),
        .nxt_we_i    (w_nxt_we),
        .nxt_waddr_i (w_nxt_waddr),
        .nxt_wdata_i (w_nxt_wdata),
        .prv_raddr_i (w_prv_raddr),
        .prv_rdata_o (w_prv_rdata),
        .prv_we_i    (w_prv_we),
        .prv_waddr_i (w_prv_waddr),
        .prv_wdata_i (w_prv_wdata)
    );

    // ------------------------------------------------------------------
    // Ring selection. Out-of-range list numbers are clamped to 0 for
    // indexing only; such commands always take the reject path.
    // ------------------------------------------------------------------
    logic              w_in_ok, w_q_ok;
    logic [LIST_W-1:0] w_in_sel, w_q_sel;
    logic [TID_W-1:0]  w_head;
    logic [TID_W:0]    w_cnt;

    assign w_in_ok  = ({1'b0, list_i} < c_nlist);
    assign w_in_sel = w_in_ok ? list_i : '0;
    assign w_q_ok   = ({1'b0, list_q} < c_nlist);
    assign w_q_sel  = w_q_ok ? list_q : '0;
    assign w_head   = head_q[w_q_sel];
    assign w_cnt    = cnt_q[w_q_sel];

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        list_d    = list_q;
        tid_d     = tid_q;
        pv_d      = pv_q;
        nx_d      = nx_q;
        head_d    = head_q;
        headv_d   = headv_q;
        cnt_d     = cnt_q;
        member_d  = member_q;
        res_tid_d = res_tid_q;
        res_err_d = res_err_q;
        res_cnt_d = res_cnt_q;

        // Both read ports look at the current head unless a state says otherwise.
        w_nxt_raddr = {w_q_sel, w_head};
        w_prv_raddr = {w_q_sel, w_head};
        w_nxt_we    = 1'b0;
        w_nxt_waddr = '0;
        w_nxt_wdata = '0;
        w_prv_we    = 1'b0;
        w_prv_waddr = '0;
        w_prv_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (iof_is_cmd(cmd_i)) begin
                    cmd_d  = cmd_i;
                    list_d = list_i;
                    tid_d  = tid_i;
                    if (!w_in_ok) begin
                        state_d = ST_REJECT;
                    end else begin
                        case (cmd_i)
                            IOF_INSERT: begin
                                if (member_q[w_in_sel][tid_i]) begin
                                    state_d = ST_REJECT;
                                end else if (!headv_q[w_in_sel]) begin
                                    state_d = ST_INS0;
                                end else begin
                                    state_d = ST_INS1;
                                end
                            end
                            IOF_REMOVE: begin
                                state_d = member_q[w_in_sel][tid_i] ? ST_REM1 : ST_REJECT;
                            end
                            IOF_FLUSH: begin
                                state_d = ST_FLUSH;
                            end
                            default: begin
                                // GETNXT / GETPRV / GETHEAD need a non-empty ring.
                                state_d = headv_q[w_in_sel] ? ST_RDLINK : ST_REJECT;
                            end
                        endcase
                    end
                end
            end

            ST_REJECT: begin
                res_err_d = 1'b1;
                res_tid_d = c_tid_none;
                res_cnt_d = w_q_ok ? w_cnt : '0;
                state_d   = ST_IDLE;
            end

            ST_RDLINK: begin
                res_err_d = 1'b0;
                res_cnt_d = w_cnt;
                if (cmd_q == IOF_GETNXT) begin
                    head_d[w_q_sel] = w_nxt_rdata;
                    res_tid_d       = {1'b0, w_nxt_rdata};
                end else if (cmd_q == IOF_GETPRV) begin
                    head_d[w_q_sel] = w_prv_rdata;
                    res_tid_d       = {1'b0, w_prv_rdata};
                end else begin
                    res_tid_d = {1'b0, w_head};
                end
                state_d = ST_IDLE;
            end

            ST_INS0: begin
                // First member links to itself in both directions.
                w_nxt_we                 = 1'b1;
                w_nxt_waddr              = {w_q_sel, tid_q};
                w_nxt_wdata              = tid_q;
                w_prv_we                 = 1'b1;
                w_prv_waddr              = {w_q_sel, tid_q};
                w_prv_wdata              = tid_q;
                head_d[w_q_sel]          = tid_q;
                headv_d[w_q_sel]         = 1'b1;
                member_d[w_q_sel][tid_q] = 1'b1;
                cnt_d[w_q_sel]           = c_cnt_one;
                res_tid_d                = {1'b0, tid_q};
                res_err_d                = 1'b0;
                res_cnt_d                = c_cnt_one;
                state_d                  = ST_IDLE;
            end

            ST_INS1: begin
                // Capture the old tail, then point head back at the new task.
                pv_d        = w_prv_rdata;
                w_prv_we    = 1'b1;
                w_prv_waddr = {w_q_sel, w_head};
                w_prv_wdata = tid_q;
                state_d     = ST_INS2;
            end

            ST_INS2: begin
                w_nxt_we    = 1'b1;
                w_nxt_waddr = {w_q_sel, pv_q};
                w_nxt_wdata = tid_q;
                state_d     = ST_INS3;
            end

            ST_INS3: begin
                w_nxt_we                 = 1'b1;
                w_nxt_waddr              = {w_q_sel, tid_q};
                w_nxt_wdata              = w_head;
                w_prv_we                 = 1'b1;
                w_prv_waddr              = {w_q_sel, tid_q};
                w_prv_wdata              = pv_q;
                member_d[w_q_sel][tid_q] = 1'b1;
                cnt_d[w_q_sel]           = w_cnt + c_cnt_one;
                res_tid_d                = {1'b0, tid_q};
                res_err_d                = 1'b0;
                res_cnt_d                = w_cnt + c_cnt_one;
                state_d                  = ST_IDLE;
            end

            ST_REM1: begin
                w_nxt_raddr = {w_q_sel, tid_q};
                w_prv_raddr = {w_q_sel, tid_q};
                nx_d        = w_nxt_rdata;
                pv_d        = w_prv_rdata;
                state_d     = ST_REM2;
            end

            ST_REM2: begin
                w_prv_we    = 1'b1;
                w_prv_waddr = {w_q_sel, nx_q};
                w_prv_wdata = pv_q;
                state_d     = ST_REM3;
            end

            ST_REM3: begin
                // For a single-member ring nx == pv == tid, so the splice
                // writes are self-links that are discarded with membership.
                w_nxt_we                 = 1'b1;
                w_nxt_waddr              = {w_q_sel, pv_q};
                w_nxt_wdata              = nx_q;
                member_d[w_q_sel][tid_q] = 1'b0;
                cnt_d[w_q_sel]           = w_cnt - c_cnt_one;
                res_cnt_d                = w_cnt - c_cnt_one;
                res_err_d                = 1'b0;
                if (tid_q == w_head) begin
                    head_d[w_q_sel] = nx_q;
                end
                if (w_cnt == c_cnt_one) begin
                    headv_d[w_q_sel] = 1'b0;
                    res_tid_d        = c_tid_none;
                end else begin
                    res_tid_d = (tid_q == w_head) ? {1'b0, nx_q} : {1'b0, w_head};
                end
                state_d = ST_IDLE;
            end

            ST_FLUSH: begin
                // Links stay stale; clearing membership makes them unreachable.
                member_d[w_q_sel] = '0;
                headv_d[w_q_sel]  = 1'b0;
                cnt_d[w_q_sel]    = '0;
                res_tid_d         = c_tid_none;
                res_err_d         = 1'b0;
                res_cnt_d         = '0;
                state_d           = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            list_q    <= '0;
            tid_q     <= '0;
            pv_q      <= '0;
            nx_q      <= '0;
            head_q    <= '0;
            headv_q   <= '0;
            cnt_q     <= '0;
            member_q  <= '0;
            res_tid_q <= c_tid_none;
            res_err_q <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            list_q    <= list_d;
            tid_q     <= tid_d;
            pv_q      <= pv_d;
            nx_q      <= nx_d;
            head_q    <= head_d;
            headv_q   <= headv_d;
            cnt_q     <= cnt_d;
            member_q  <= member_d;
            res_tid_q <= res_tid_d;
            res_err_q <= res_err_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign tid_o  = res_tid_q;
    assign err_o  = res_err_q;
    assign cnt_o  = res_cnt_q;
    assign done_o = (state_q == ST_IDLE);

endmodule
`default_nettype wire
